// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rxd,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_pop,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        overrun,
  output logic                        frame_err,
  output logic                        parity_err,
  input  logic                        err_clr
);

  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF  = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULLC = CW'(CPB - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BRK   = 3'd5;

  logic          sync_q;
  logic          rxs_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tick;
  logic          push;
  logic          set_fe;
  logic          set_pe;
`ifdef UART_RX_PARITY_EN
  logic          pbad_q, pbad_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wp_q, rp_q;
  logic          empty, full;
  logic          do_pop, do_push, drop;
  logic          ovr_q, fe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxs_q  <= sync_q;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    set_fe  = 1'b0;
    set_pe  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
`endif
    // bit-period timer runs only while a frame is in flight
    if (state_q != S_IDLE && state_q != S_BRK)
      cnt_d = tick ? FULLC : cnt_q - 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = HALF;
        end
      end
      S_START: begin
        bit_d = 3'd0;
        if (tick) state_d = rxs_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          sh_d  = {rxs_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PAR;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (tick) begin
          pbad_d  = rxs_q != ^sh_q;
          set_pe  = rxs_q != ^sh_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            push = !pbad_q;
`else
            push = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            set_fe  = 1'b1;
            state_d = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = rx_pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wp_q[AW-1:0]] <= sh_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  // a same-cycle set overrides err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ovr_q <= drop   | (ovr_q & ~err_clr);
      fe_q  <= set_fe | (fe_q & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pe_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pe_q   <= 1'b0;
      pbad_q <= 1'b0;
    end else begin
      pe_q   <= set_pe | (pe_q & ~err_clr);
      pbad_q <= pbad_d;
    end
  end
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0 & set_pe;
`endif

  assign rx_data   = mem_q[rp_q[AW-1:0]];
  assign rx_valid  = !empty;
  assign rx_count  = wp_q - rp_q;
  assign overrun   = ovr_q;
  assign frame_err = fe_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames, queue model, per-cycle compare.
module tb_uart_rx_fifo;
  localparam int CPB   = 10;
  localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       overrun, frame_err, parity_err;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(10_000_000),
    .BAUD_RATE  (1_000_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_pop    (rx_pop),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .err_clr   (err_clr)
  );

  int         nvec = 0;
  int         nerr = 0;
  bit         chk_en = 1'b0;
  logic [7:0] mq[$];
  bit         m_ovr = 1'b0;
  bit         m_fe = 1'b0;
  bit         m_pe = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("valid", 32'(rx_valid), 32'(mq.size() != 0));
      chk("count", 32'(rx_count), 32'(mq.size()));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("frame_err", 32'(frame_err), 32'(m_fe));
      chk("parity_err", 32'(parity_err), 32'(m_pe));
      if (mq.size() != 0) chk("data", 32'(rx_data), 32'(mq[0]));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drives one frame; the model changes at the negedge before the
  // clock edge where the receiver samples parity/stop
  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input bit par, input int lim);
    logic [10:0] bits;
    int nb, np_stop, np_par;
    nb = PAR ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (PAR) begin
      bits[9] = par;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    np_stop = 2 + CPB / 2 + (nb - 1) * CPB;
    np_par = np_stop - CPB;
    for (int n = 0; n < nb * CPB && n < lim; n++) begin
      @(negedge clk);
      if (n % CPB == 0) rxd = bits[n / CPB];
      if (PAR && n == np_par && par != ^b) m_pe = 1'b1;
      if (n == np_stop) begin
        if (!stop) m_fe = 1'b1;
        else if (!PAR || par == ^b) begin
          if (mq.size() == DEPTH) m_ovr = 1'b1;
          else mq.push_back(b);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, ^b, 1000);
  endtask

  task automatic pop_any();
    @(negedge clk);
    rx_pop = 1'b1;
    if (mq.size() != 0) void'(mq.pop_front());
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    @(negedge clk);
    chk("head", 32'(rx_data), 32'(exp));
    rx_pop = 1'b1;
    if (mq.size() != 0) void'(mq.pop_front());
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    err_clr = 1'b1;
    m_ovr = 1'b0;
    m_fe = 1'b0;
    m_pe = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_count", 32'(rx_count), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_pe", 32'(parity_err), 32'd0);
    chk_en = 1'b1;
    idle(2 * CPB);

    send(8'h55);
    chk("t1_valid", 32'(rx_valid), 32'd1);
    chk("t1_data", 32'(rx_data), 32'h55);
    chk("t1_count", 32'(rx_count), 32'd1);
    pop_any();
    chk("t1_empty", 32'(rx_valid), 32'd0);
    pop_any();
    chk("t1_popempty", 32'(rx_count), 32'd0);
    idle(CPB);

    @(negedge clk);
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(2 * CPB);
    chk("t2_noflag", 32'(frame_err), 32'd0);
    chk("t2_nopush", 32'(rx_valid), 32'd0);
    send(8'hA3);
    chk("t2_data", 32'(rx_data), 32'hA3);
    pop_chk(8'hA3);

    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("t3_count", 32'(rx_count), 32'd8);
    chk("t3_ovr", 32'(overrun), 32'd1);
    for (int i = 1; i <= 8; i++) pop_chk(8'(i));
    chk("t3_empty", 32'(rx_valid), 32'd0);
    clr();
    chk("t3_clr", 32'(overrun), 32'd0);

    send_frame(8'hA5, 1'b0, ^8'hA5, 1000);
    idle(30 * CPB);
    chk("t4_fe", 32'(frame_err), 32'd1);
    chk("t4_count", 32'(rx_count), 32'd0);
    rxd = 1'b1;
    idle(2 * CPB);
    send(8'h3C);
    chk("t4_data", 32'(rx_data), 32'h3C);
    pop_any();
    clr();
    chk("t4_clr", 32'(frame_err), 32'd0);

    send(8'h11);
    send(8'h22);
    chk("t5_pre", 32'(rx_count), 32'd2);
    send_frame(8'h9A, 1'b1, ^8'h9A, 6 * CPB);
    @(negedge clk);
    reset = 1'b1;
    rxd = 1'b1;
    mq.delete();
    m_ovr = 1'b0;
    m_fe = 1'b0;
    m_pe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_count", 32'(rx_count), 32'd0);
    chk("t5_valid", 32'(rx_valid), 32'd0);
    idle(2 * CPB);
    send(8'hC3);
    chk("t5_only", 32'(rx_count), 32'd1);
    pop_chk(8'hC3);
    chk("t5_empty", 32'(rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1000);
    chk("t6_pe", 32'(parity_err), 32'd1);
    chk("t6_drop", 32'(rx_count), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 1000);
    chk("t6_count", 32'(rx_count), 32'd1);
    chk("t6_data", 32'(rx_data), 32'h07);
`else
    send_frame(8'h07, 1'b1, 1'b0, 1000);
    chk("t6_pe", 32'(parity_err), 32'd0);
    chk("t6_count", 32'(rx_count), 32'd1);
    chk("t6_data", 32'(rx_data), 32'h07);
`endif
    pop_any();
    idle(CPB);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
